// File: rtl/mdu_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer.
package mdu_pkg;

    // Shared ALU opcodes; the ALU takes carry-in from Op[2], so SUB is a + ~b + 1
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // md_op encoding: bit 1 selects divide, bit 0 selects signed
    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    // Last iteration index of the 32-step shift loop
    localparam int ITER_LAST = 31;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABS_A  = 3'd1,
        S_ABS_B  = 3'd2,
        S_ITER   = 3'd3,
        S_FIX_LO = 3'd4,
        S_FIX_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer that borrows the EX-stage ALU while busy.
// Signed ops run on magnitudes; sign fix-up happens in FIX_LO/FIX_HI.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      md_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_cout,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic            busy,
    output logic            done,
    output logic            div0,
    output logic [XLEN-1:0] result_lo,
    output logic [XLEN-1:0] result_hi
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    // acc: product accumulator (mul) or partial remainder (div)
    // ra : shifting multiplicand (mul) or dividend/quotient (div)
    // rb : shifting multiplier (mul) or divisor (div)
    logic [XLEN-1:0]   acc, ra, rb;
    logic [XLEN-1:0]   acc_step, ra_step, rb_step;
    logic              is_div, is_sgn, sign_a, sign_b;

    logic              op_div, op_sgn, accept, zero_div, iter_last, div_take;
    logic [XLEN-1:0]   r_shift;

    assign op_div    = (md_op == MD_DIVU) || (md_op == MD_DIV);
    assign op_sgn    = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign accept    = (state == S_IDLE) && start && !flush;
    assign zero_div  = op_div && (src_b == '0);
    assign iter_last = (cnt == CNT_W'(ITER_LAST));

    // Divide trial: shift next dividend bit into the remainder. If the old
    // remainder MSB was set the 33-bit value already exceeds any divisor.
    assign r_shift  = {acc[XLEN-2:0], ra[XLEN-1]};
    assign div_take = acc[XLEN-1] | alu_cout;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; flush overrides every non-idle state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = zero_div ? S_DONE : (op_sgn ? S_ABS_A : S_ITER);
            S_ABS_A:  state_nxt = S_ABS_B;
            S_ABS_B:  state_nxt = S_ITER;
            S_ITER:   if (iter_last) state_nxt = is_sgn ? S_FIX_LO : S_DONE;
            S_FIX_LO: state_nxt = S_FIX_HI;
            S_FIX_HI: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (flush && state != S_IDLE) state_nxt = S_IDLE;
    end

    // ALU operand routing; everything is zero while the ALU is not owned
    always_comb begin
        alu_own = 1'b0;
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = 4'b0000;
        case (state)
            S_ABS_A: begin
                alu_own = 1'b1; alu_b = ra; alu_op = ALU_SUB;
            end
            S_ABS_B: begin
                alu_own = 1'b1; alu_b = rb; alu_op = ALU_SUB;
            end
            S_ITER: begin
                alu_own = 1'b1;
                if (is_div) begin
                    alu_a = r_shift; alu_b = rb; alu_op = ALU_SUB;
                end else begin
                    alu_a = acc; alu_b = ra; alu_op = ALU_ADD;
                end
            end
            S_FIX_LO: begin
                alu_own = 1'b1; alu_b = is_div ? ra : acc; alu_op = ALU_SUB;
            end
            S_FIX_HI: begin
                // Multiply still spends this cycle so signed latency is fixed
                alu_own = 1'b1;
                if (is_div) begin
                    alu_b = acc; alu_op = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    // One iteration step of shift-add multiply or restoring divide
    always_comb begin
        acc_step = acc;
        ra_step  = ra;
        rb_step  = rb;
        if (is_div) begin
            acc_step = div_take ? alu_result : r_shift;
            ra_step  = {ra[XLEN-2:0], div_take};
        end else begin
            if (rb[0]) acc_step = alu_result;
            ra_step = ra << 1;
            rb_step = rb >> 1;
        end
    end

    // Datapath registers and result commit; flush blocks any commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            ra        <= '0;
            rb        <= '0;
            is_div    <= 1'b0;
            is_sgn    <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div0      <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE: if (accept) begin
                    ra     <= src_a;
                    rb     <= src_b;
                    acc    <= '0;
                    cnt    <= '0;
                    is_div <= op_div;
                    is_sgn <= op_sgn;
                    sign_a <= 1'b0;
                    sign_b <= 1'b0;
                    if (zero_div) begin
                        result_lo <= '1;
                        result_hi <= src_a;
                        div0      <= 1'b1;
                    end
                end
                S_ABS_A: begin
                    sign_a <= ra[XLEN-1];
                    if (ra[XLEN-1]) ra <= alu_result;
                end
                S_ABS_B: begin
                    sign_b <= rb[XLEN-1];
                    if (rb[XLEN-1]) rb <= alu_result;
                end
                S_ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= acc_step;
                    ra  <= ra_step;
                    rb  <= rb_step;
                    if (iter_last && !is_sgn) begin
                        result_lo <= is_div ? ra_step : acc_step;
                        result_hi <= is_div ? acc_step : '0;
                        div0      <= 1'b0;
                    end
                end
                S_FIX_LO: if (sign_a ^ sign_b) begin
                    if (is_div) ra  <= alu_result;
                    else        acc <= alu_result;
                end
                S_FIX_HI: begin
                    result_lo <= is_div ? ra : acc;
                    result_hi <= is_div ? (sign_a ? alu_result : acc) : '0;
                    div0      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: external ALU model, arithmetic reference
// model with latency tracking, per-cycle compare plus directed literal checks.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  md_op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        alu_own;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        busy, done, div0;
    logic [31:0] result_lo, result_hi;

    int n_cmp = 0;
    int n_err = 0;

    mdu_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .alu_result(alu_result), .alu_cout(alu_cout),
        .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .busy(busy), .done(done), .div0(div0),
        .result_lo(result_lo), .result_hi(result_hi)
    );

    always #5 clk = ~clk;

    // Shared EX-stage ALU: carry-in comes from Op[2]
    logic [32:0] alu_sum;
    assign alu_sum    = {1'b0, alu_a} + {1'b0, (alu_op[2] ? ~alu_b : alu_b)} + {32'd0, alu_op[2]};
    assign alu_result = alu_sum[31:0];
    assign alu_cout   = alu_sum[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from arithmetic on magnitudes
    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        d0;
        logic [7:0]  lat;
    } exp_t;

    function automatic exp_t calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] ma, mb, q, r;
        logic sa, sb;
        sa = op[0] & a[31];
        sb = op[0] & b[31];
        ma = sa ? 32'd0 - a : a;
        mb = sb ? 32'd0 - b : b;
        e.d0  = 1'b0;
        e.lat = op[0] ? 8'd37 : 8'd33;
        if (!op[1]) begin
            e.lo = a * b;
            e.hi = '0;
        end else if (b == 32'd0) begin
            e.lo = '1; e.hi = a; e.d0 = 1'b1; e.lat = 8'd1;
        end else begin
            q = ma / mb;
            r = ma % mb;
            e.lo = (sa ^ sb) ? 32'd0 - q : q;
            e.hi = sa ? 32'd0 - r : r;
        end
        return e;
    endfunction

    exp_t cur, pend;
    always_comb cur = calc(md_op, src_a, src_b);

    // Model state: phase counts cycles since the start edge; done when phase == lat
    logic        m_busy = 1'b0;
    logic [7:0]  m_phase = '0;
    logic [31:0] m_lo = '0, m_hi = '0;
    logic        m_d0 = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_phase <= '0; pend <= '0;
            m_lo <= '0; m_hi <= '0; m_d0 <= 1'b0;
        end else if (!m_busy) begin
            if (start && !flush) begin
                pend <= cur; m_busy <= 1'b1; m_phase <= 8'd1;
                if (cur.lat == 8'd1) begin
                    m_lo <= cur.lo; m_hi <= cur.hi; m_d0 <= cur.d0;
                end
            end
        end else if (flush || m_phase == pend.lat) begin
            m_busy <= 1'b0;
        end else begin
            m_phase <= m_phase + 8'd1;
            if (m_phase + 8'd1 == pend.lat) begin
                m_lo <= pend.lo; m_hi <= pend.hi; m_d0 <= pend.d0;
            end
        end
    end

    // Per-cycle comparison against the model
    logic exp_done, exp_own;
    always @(negedge clk) begin
        exp_done = m_busy && (m_phase == pend.lat);
        exp_own  = m_busy && !exp_done;
        chk1("cyc busy", busy, m_busy);
        chk1("cyc done", done, exp_done);
        chk1("cyc alu_own", alu_own, exp_own);
        chk("cyc result_lo", result_lo, m_lo);
        chk("cyc result_hi", result_hi, m_hi);
        chk1("cyc div0", div0, m_d0);
        if (!exp_own) begin
            chk("cyc idle alu_a", alu_a, 32'd0);
            chk("cyc idle alu_b", alu_b, 32'd0);
            chk("cyc idle alu_op", {28'd0, alu_op}, 32'd0);
        end
    end

    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic ed0, input int elat);
        int n;
        @(posedge clk); #1;
        md_op = op; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(elat));
        chk({nm, " lo"}, result_lo, elo);
        chk({nm, " hi"}, result_hi, ehi);
        chk1({nm, " div0"}, div0, ed0);
        @(posedge clk); #1;
        chk1({nm, " busy after"}, busy, 1'b0);
    endtask

    exp_t pin;
    int   ndone;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("reset busy", busy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk1("reset alu_own", alu_own, 1'b0);
        chk("reset result_lo", result_lo, 32'd0);
        chk("reset result_hi", result_hi, 32'd0);
        reset = 1'b0;

        // Pin the reference model with hand-computed values
        pin = calc(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("model mult wrap", pin.lo, 32'h8000_0000);
        pin = calc(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("model div wrap q", pin.lo, 32'h8000_0000);
        chk("model div wrap r", pin.hi, 32'd0);
        pin = calc(2'b11, 32'hFFFF_FFF9, 32'd2);
        chk("model div neg r", pin.hi, 32'hFFFF_FFFF);
        chk("model div neg lat", 32'(pin.lat), 32'd37);

        // Directed operations
        run_op("multu 7x6",      2'b00, 32'd7,          32'd6,          32'h0000_002A, 32'd0,          1'b0, 33);
        run_op("mult -3x5",      2'b01, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 32'd0,          1'b0, 37);
        run_op("div -7/2",       2'b11, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF,  1'b0, 37);
        run_op("divu ff/1",      2'b10, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 32'd0,          1'b0, 33);
        run_op("divu by zero",   2'b10, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF, 32'h0000_1234,  1'b1, 1);
        run_op("mult wrap",      2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'd0,          1'b0, 37);
        run_op("div wrap",       2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'd0,          1'b0, 37);
        run_op("div 7/-2",       2'b11, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,          1'b0, 37);
        run_op("divu 100/7",     2'b10, 32'd100,        32'd7,          32'd14,        32'd2,          1'b0, 33);
        run_op("multu ffxff",    2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,         32'd0,          1'b0, 33);

        // Flush at iteration count 10
        @(posedge clk); #1;
        md_op = 2'b00; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk1("flush busy", busy, 1'b0);
        chk1("flush alu_own", alu_own, 1'b0);
        chk("flush result_lo held", result_lo, 32'd1);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("flush no done", 32'(ndone), 32'd0);

        // start while busy is ignored
        @(posedge clk); #1;
        md_op = 2'b00; src_a = 32'd7; src_b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        md_op = 2'b10; src_a = 32'd99; src_b = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        while (done !== 1'b1 && ndone < 200) begin
            @(posedge clk); #1;
            ndone++;
        end
        chk1("busy-start done seen", done, 1'b1);
        chk("busy-start result_lo", result_lo, 32'h0000_002A);
        chk1("busy-start div0", div0, 1'b0);
        @(posedge clk); #1;

        // start and flush together in IDLE
        md_op = 2'b00; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk1("start+flush busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk1("start+flush still idle", busy, 1'b0);
        chk("start+flush result held", result_lo, 32'h0000_002A);

        // Asynchronous reset in the middle of ITER
        md_op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk1("async rst busy", busy, 1'b0);
        chk1("async rst done", done, 1'b0);
        chk1("async rst alu_own", alu_own, 1'b0);
        chk("async rst alu_a", alu_a, 32'd0);
        chk("async rst alu_b", alu_b, 32'd0);
        chk("async rst result_lo", result_lo, 32'd0);
        chk("async rst result_hi", result_hi, 32'd0);
        chk1("async rst div0", div0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Normal operation resumes after reset
        run_op("post-reset divu", 2'b10, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer for the DLX EX stage.
- Time-shares the existing 32-bit ALU: while busy it owns the ALU inputs and runs shift-add multiply or restoring divide, one ALU operation per cycle.
- Signed operations are handled by negating the operands before iteration and fixing the result signs afterwards.
- Pipeline hazard logic stalls on busy.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- CNT_W, 6, iteration counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- flush  in  1  abort current operation (pipeline squash)
- md_op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- src_a  in  32  multiplicand/dividend
- src_b  in  32  multiplier/divisor
- alu_result  in  32  shared ALU sum output
- alu_cout  in  1  shared ALU MSB carry-out (1 = no borrow on SUB)
- alu_own  out  1  1 = top-level mux routes alu_a/alu_b/alu_op to the ALU
- alu_a  out  32  ALU A operand
- alu_b  out  32  ALU B operand
- alu_op  out  4  ALU Op code
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div0  out  1  last divide had a zero divisor; held with results
- result_lo  out  32  product low word / quotient
- result_hi  out  32  remainder (0 for multiply)

Behaviour:
- Reset is asynchronous, active-high. Under reset every output and register is 0 and the state is IDLE. Reset mid-operation aborts the operation with no done pulse.
- ALU opcodes: ADD = 0010, SUB = 0110. The ALU supplies carry-in = Op[2].
- States: IDLE, ABS_A, ABS_B, ITER, FIX_LO, FIX_HI, DONE.
- IDLE:
  - start=1 latches src_a, src_b, md_op and sets busy.
  - Divide with src_b == 0: next state DONE with result_lo = FFFFFFFF, result_hi = src_a, div0 = 1.
  - Signed op: next state ABS_A.
  - Unsigned op: next state ITER, counter = 0.
- ABS_A / ABS_B: one cycle each, always taken for signed ops.
  - Drive alu_a = 0, alu_b = operand, op = SUB.
  - Latch alu_result only if the operand MSB is 1; otherwise keep the operand.
  - Record the sign bits.
- ITER: exactly 32 cycles; the counter increments each cycle. Leaves to FIX_LO (signed) or DONE (unsigned) when counter == 31.
- Multiply step (acc, m, q):
  - alu_a = acc, alu_b = m, op = ADD.
  - If q[0] = 1: acc <= alu_result; otherwise acc holds.
  - m <<= 1, q >>= 1.
  - Only the low 32 bits are kept.
- Divide step (rem, q, d):
  - r' = {rem[30:0], q[31]}; alu_a = r', alu_b = d, op = SUB.
  - If rem[31] = 1 or alu_cout = 1: rem <= alu_result and the shifted-in quotient bit is 1.
  - Otherwise rem <= r' and the quotient bit is 0.
  - q <<= 1 with the new bit shifted in.
- FIX_LO: negate the low result (0 − x via SUB) if sign_a XOR sign_b.
- FIX_HI:
  - Divide: negate the remainder if sign_a.
  - Multiply: no-op cycle, so latency stays fixed.
- DONE: one cycle.
  - done = 1, busy = 0 next cycle.
  - result_lo/result_hi/div0 update here and hold until the next accepted start.
- Latency from the start-sampling edge to the done cycle:
  - unsigned: 33 cycles
  - signed: 37 cycles
  - divide by zero: 1 cycle
- alu_own = 1 in ABS_A, ABS_B, ITER, FIX_LO, FIX_HI. It is 0 in IDLE and DONE. alu_a/alu_b/alu_op = 0 whenever alu_own = 0.
- start while not IDLE is ignored.
- flush in any non-IDLE state:
  - Return to IDLE next edge with no done pulse.
  - Results unchanged; busy and alu_own drop.
- start and flush in the same IDLE cycle: flush wins and start is ignored.
- Overflow cases follow two's-complement wrap:
  - MULT 80000000 × FFFFFFFF → 80000000.
  - DIV 80000000 / FFFFFFFF → q = 80000000, r = 0.

Decomposition:
- Package mdu_pkg holds:
  - ALU_ADD, ALU_SUB constants
  - md_op codes MD_MULTU, MD_MULT, MD_DIVU, MD_DIV
  - state encoding (7 states, 3 bits)
  - ITER_LAST = 31
- No sub-module. The counter, datapath registers and FSM stay in one module. The ALU is external and shared through the top-level mux on alu_own.

Test Plan:
- MULTU src_a=7, src_b=6 → done exactly 33 cycles after start; result_lo=0000002A, result_hi=0, div0=0.
- MULT src_a=FFFFFFFD (−3), src_b=5 → done at 37 cycles; result_lo=FFFFFFF1.
- DIV src_a=FFFFFFF9 (−7), src_b=2 → result_lo=FFFFFFFD, result_hi=FFFFFFFF. DIVU FFFFFFFF/1 → q=FFFFFFFF, r=0.
- DIVU src_a=1234, src_b=0 → done 1 cycle after start; result_lo=FFFFFFFF, result_hi=1234, div0=1; alu_own never asserted.
- Abort cases:
  - flush at ITER counter 10 → IDLE next edge, no done, previous results held.
  - reset asserted mid-ITER → all outputs 0 immediately, without waiting for clk.
- start pulsed while busy → ignored, original result unchanged. start+flush together in IDLE → no operation; busy stays 0.
